// File: rtl/sw_24_demux.sv
// sw_24_demux: registered one-to-two steering stage for 24-bit mantissa words.
// One valid/ready input is steered by `sel` into one of two one-entry output slots.
// Each slot drains independently through its own valid/ready pair.
// Optional feature: define SW_24_DEMUX_CNT_EN to add the per-port delivered-word
// counters cnt_0 / cnt_1.
// Reset is synchronous and active-low (rst_n).

module sw_24_demux #(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_0,
    output logic                  out_0_valid,
    input  logic                  out_0_ready,
    output logic [DATA_WIDTH-1:0] out_1,
    output logic                  out_1_valid,
    input  logic                  out_1_ready
`ifdef SW_24_DEMUX_CNT_EN
    ,
    output logic [15:0]           cnt_0,
    output logic [15:0]           cnt_1
`endif
);

    logic [DATA_WIDTH-1:0] out_0_q, out_0_d;
    logic [DATA_WIDTH-1:0] out_1_q, out_1_d;
    logic                  out_0_valid_q, out_0_valid_d;
    logic                  out_1_valid_q, out_1_valid_d;

    logic slot_0_free;
    logic slot_1_free;
    logic accept;
    logic load_0, load_1;
    logic drain_0, drain_1;

    // Handshake decode: only the targeted slot can stall the input.
    always_comb begin
        slot_0_free = ~out_0_valid_q | out_0_ready;
        slot_1_free = ~out_1_valid_q | out_1_ready;
        in_ready    = rst_n & (sel ? slot_1_free : slot_0_free);
        accept      = in_valid & in_ready;
        load_0      = accept & ~sel;
        load_1      = accept & sel;
        drain_0     = out_0_valid_q & out_0_ready;
        drain_1     = out_1_valid_q & out_1_ready;
    end

    // Slot next state: a load wins over a drain (replace-and-stay-valid).
    always_comb begin
        out_0_d       = out_0_q;
        out_0_valid_d = out_0_valid_q;
        out_1_d       = out_1_q;
        out_1_valid_d = out_1_valid_q;

        if (load_0) begin
            out_0_d       = in_data;
            out_0_valid_d = 1'b1;
        end else if (drain_0) begin
            out_0_valid_d = 1'b0;
        end

        if (load_1) begin
            out_1_d       = in_data;
            out_1_valid_d = 1'b1;
        end else if (drain_1) begin
            out_1_valid_d = 1'b0;
        end
    end

    // Slot registers; reset discards any held word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_0_q       <= '0;
            out_1_q       <= '0;
            out_0_valid_q <= 1'b0;
            out_1_valid_q <= 1'b0;
        end else begin
            out_0_q       <= out_0_d;
            out_1_q       <= out_1_d;
            out_0_valid_q <= out_0_valid_d;
            out_1_valid_q <= out_1_valid_d;
        end
    end

    assign out_0       = out_0_q;
    assign out_1       = out_1_q;
    assign out_0_valid = out_0_valid_q;
    assign out_1_valid = out_1_valid_q;

`ifdef SW_24_DEMUX_CNT_EN
    logic [15:0] cnt_0_q, cnt_0_d;
    logic [15:0] cnt_1_q, cnt_1_d;

    // Delivered-word counters; natural 16-bit wrap.
    always_comb begin
        cnt_0_d = cnt_0_q;
        cnt_1_d = cnt_1_q;
        if (drain_0) begin
            cnt_0_d = cnt_0_q + 16'd1;
        end
        if (drain_1) begin
            cnt_1_d = cnt_1_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_0_q <= '0;
            cnt_1_q <= '0;
        end else begin
            cnt_0_q <= cnt_0_d;
            cnt_1_q <= cnt_1_d;
        end
    end

    assign cnt_0 = cnt_0_q;
    assign cnt_1 = cnt_1_q;
`endif

endmodule

// File: tb/tb_sw_24_demux.sv
// Directed testbench for sw_24_demux. Inputs change 1 time unit after each rising
// edge; outputs are checked at that point, away from the active edge.
// Counter checks run only when SW_24_DEMUX_CNT_EN is defined.

module tb_sw_24_demux;

    logic        clk;
    logic        rst_n;
    logic [23:0] in_data;
    logic        sel;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_0;
    logic        out_0_valid;
    logic        out_0_ready;
    logic [23:0] out_1;
    logic        out_1_valid;
    logic        out_1_ready;
`ifdef SW_24_DEMUX_CNT_EN
    logic [15:0] cnt_0;
    logic [15:0] cnt_1;
`endif

    int n_vec;
    int n_err;

    sw_24_demux #(
        .DATA_WIDTH(24)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_0      (out_0),
        .out_0_valid(out_0_valid),
        .out_0_ready(out_0_ready),
        .out_1      (out_1),
        .out_1_valid(out_1_valid),
        .out_1_ready(out_1_ready)
`ifdef SW_24_DEMUX_CNT_EN
        ,
        .cnt_0      (cnt_0),
        .cnt_1      (cnt_1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [23:0] d);
        in_valid = v;
        sel      = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        sel         = 1'b0;
        in_data     = 24'h00007B;
        out_0_ready = 1'b1;
        out_1_ready = 1'b1;

        // Reset held for two edges with in_valid high.
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_v0", {31'd0, out_0_valid}, 32'd0);
        check("rst_v1", {31'd0, out_1_valid}, 32'd0);
        check("rst_d0", {8'd0, out_0}, 32'd0);
        check("rst_d1", {8'd0, out_1}, 32'd0);
`ifdef SW_24_DEMUX_CNT_EN
        check("rst_cnt0", {16'd0, cnt_0}, 32'd0);
        check("rst_cnt1", {16'd0, cnt_1}, 32'd0);
`endif
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 24'd0);
        step();

        // Basic steer: 35 -> port 0, then 27 -> port 1.
        drive(1'b1, 1'b0, 24'd35);
        check("basic_rdy0", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b1, 1'b1, 24'd27);
        check("basic_d0", {8'd0, out_0}, 32'd35);
        check("basic_v0", {31'd0, out_0_valid}, 32'd1);
        check("basic_v1_lo", {31'd0, out_1_valid}, 32'd0);
        step();
        drive(1'b0, 1'b0, 24'd0);
        check("basic_v0_drop", {31'd0, out_0_valid}, 32'd0);
        check("basic_d1", {8'd0, out_1}, 32'd27);
        check("basic_v1", {31'd0, out_1_valid}, 32'd1);
        step();
        check("basic_v1_drop", {31'd0, out_1_valid}, 32'd0);

        // Backpressure on port 1.
        out_1_ready = 1'b0;
        drive(1'b1, 1'b1, 24'hFFFFFF);
        check("bp_rdy_first", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b1, 1'b1, 24'h000F10);
        check("bp_rdy_stall", {31'd0, in_ready}, 32'd0);
        check("bp_hold_d1", {8'd0, out_1}, 32'h00FFFFFF);
        step();
        check("bp_hold2_d1", {8'd0, out_1}, 32'h00FFFFFF);
        check("bp_hold2_v1", {31'd0, out_1_valid}, 32'd1);
        check("bp_rdy_stall2", {31'd0, in_ready}, 32'd0);
        out_1_ready = 1'b1;
        #1;
        check("bp_rdy_drain", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b0, 1'b0, 24'd0);
        check("bp_new_d1", {8'd0, out_1}, 32'h00000F10);
        check("bp_new_v1", {31'd0, out_1_valid}, 32'd1);
        step();
        check("bp_done_v1", {31'd0, out_1_valid}, 32'd0);

        // Alternating ports back-to-back keep full throughput.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[0], 24'h000100 + 24'(i));
            check("alt_rdy", {31'd0, in_ready}, 32'd1);
            step();
        end
        drive(1'b0, 1'b0, 24'd0);
        check("alt_d1", {8'd0, out_1}, 32'h00000103);
        check("alt_d0", {8'd0, out_0}, 32'h00000102);
        step();

        // Independence: port 1 full and stalled, port 0 still accepts.
        out_1_ready = 1'b0;
        out_0_ready = 1'b0;
        drive(1'b1, 1'b1, 24'hABCDEF);
        step();
        drive(1'b1, 1'b0, 24'h000000);
        check("ind_rdy0", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b1, 1'b1, 24'h000005);
        check("ind_d0", {8'd0, out_0}, 32'd0);
        check("ind_v0", {31'd0, out_0_valid}, 32'd1);
        check("ind_d1", {8'd0, out_1}, 32'h00ABCDEF);
        check("ind_rdy1_stall", {31'd0, in_ready}, 32'd0);

        // Reset mid-operation with both slots full.
        drive(1'b0, 1'b0, 24'd0);
        rst_n = 1'b0;
        #1;
        check("mrst_rdy", {31'd0, in_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        out_0_ready = 1'b1;
        out_1_ready = 1'b1;
        #1;
        check("mrst_v0", {31'd0, out_0_valid}, 32'd0);
        check("mrst_v1", {31'd0, out_1_valid}, 32'd0);
        check("mrst_d1", {8'd0, out_1}, 32'd0);
        check("mrst_d0", {8'd0, out_0}, 32'd0);
        step();
        check("mrst_no_deliver", {30'd0, out_1_valid, out_0_valid}, 32'd0);

`ifdef SW_24_DEMUX_CNT_EN
        // Three words to port 0.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 24'(i + 1));
            step();
        end
        drive(1'b0, 1'b0, 24'd0);
        step();
        check("cnt0_three", {16'd0, cnt_0}, 32'd3);
        check("cnt1_zero", {16'd0, cnt_1}, 32'd0);

        // 65535 drains on port 1, then one more to wrap.
        drive(1'b1, 1'b1, 24'h000777);
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        drive(1'b0, 1'b0, 24'd0);
        step();
        check("cnt1_ffff", {16'd0, cnt_1}, 32'h0000FFFF);
        drive(1'b1, 1'b1, 24'h000888);
        step();
        drive(1'b0, 1'b0, 24'd0);
        step();
        check("cnt1_wrap", {16'd0, cnt_1}, 32'd0);
        check("cnt0_kept", {16'd0, cnt_0}, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sw_24_demux.md
# sw_24_demux

Registered 24-bit one-to-two steering stage, the inverse of the 24-bit 2:1 operand selector. It accepts one 24-bit word per cycle under a valid/ready handshake and delivers it to output port 0 or port 1 according to `sel`. Each output has its own one-entry holding register. It sits downstream of the FP datapath's mantissa select/swap logic and returns a normalised or aligned mantissa to the operand lane it came from.

## Interface
- `DATA_WIDTH`, 24, word width on all data ports.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_data` input DATA_WIDTH: word to steer.
- `sel` input 1: destination; 0 → port 0, 1 → port 1. Qualified by `in_valid`.
- `in_valid` input 1: `in_data`/`sel` are valid.
- `in_ready` output 1: the stage accepts the word this cycle.
- `out_0` output DATA_WIDTH: port 0 data register.
- `out_0_valid` output 1: `out_0` holds an undelivered word.
- `out_0_ready` input 1: port 0 consumer accepts.
- `out_1`, `out_1_valid`, `out_1_ready`: same as port 0, for port 1.
- `cnt_0`, `cnt_1` output 16 each: delivered-word counters. Present only with `SW_24_DEMUX_CNT_EN`.

## Operation
- Slot k (k = 0, 1) has data register `out_k` and flag `out_k_valid`.
- Slot k drains when `out_k_valid & out_k_ready`.
- `in_ready` = `rst_n` & (`sel` ? (~`out_1_valid` | `out_1_ready`) : (~`out_0_valid` | `out_0_ready`)).
  - Combinational from `sel` and the target slot only.
  - The non-selected slot never stalls the input.
- Accept = `in_valid & in_ready`. On accept, `out_sel` ← `in_data` and `out_sel_valid` ← 1.
- Slot k next state, per cycle:
  - load and drain in the same cycle: data replaced, valid stays 1;
  - drain only: valid ← 0, data held;
  - neither: hold.
- `out_k` and `out_k_valid` are stable while `out_k_valid=1 & out_k_ready=0`.
- The two ports are independent. No ordering holds between words sent to different ports. Words sent to the same port leave in arrival order.
- Values of `in_data`/`sel` while `in_valid=0` are ignored. No state changes.
- `sel` may change every cycle. Back-to-back words alternating ports give full throughput.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `out_0`, `out_1` ← 0; `out_0_valid`, `out_1_valid` ← 0; counters ← 0.
  - `in_ready` is 0 while `rst_n`=0.
- Reset mid-operation discards held words. Nothing is delivered after the reset edge.
- Latency: a word accepted at edge N is visible on `out_sel`, with valid=1, after edge N.
  - It can be consumed in the cycle following edge N.
- Throughput: 1 word/cycle per port while that port's consumer holds ready=1.
- A full slot with ready=0 stalls only inputs that select it. `in_ready`=0 until that slot drains.

## Configuration
- `SW_24_DEMUX_CNT_EN` defined:
  - `cnt_k` increments by 1 on every drain of slot k.
  - 16-bit, wraps 0xFFFF → 0x0000.
  - Reset to 0.
- Not defined: the `cnt_0`/`cnt_1` ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `in_ready`=0, both valids 0, `out_0`=`out_1`=0.
- Basic steer: in 35 with sel=0, then 27 with sel=1, both readies=1.
  - `out_0`=35 one cycle after the first accept.
  - `out_1`=27 one cycle after the second accept.
  - Each valid is high for exactly 1 cycle.
- Backpressure: `out_1_ready`=0, send 0xFFFFFF with sel=1, then 0x000F10 with sel=1.
  - `out_1` holds 0xFFFFFF and `in_ready`=0 for the second word.
  - Raise `out_1_ready` → 0x000F10 is accepted in the drain cycle and appears next cycle.
- Independence: port 1 stalled and full, send 0x000000 with sel=0 → accepted immediately, `out_0`=0x000000, `out_0_valid`=1.
- Reset mid-operation: both slots full with ready=0, pulse `rst_n`=0 for 1 cycle → both valids 0 and data 0 after the edge.
- With `SW_24_DEMUX_CNT_EN`:
  - 3 words to port 0 → `cnt_0`=3, `cnt_1`=0.
  - Preload the count to 0xFFFF via 65535 drains, then one more drain → wraps to 0x0000.
